// File: rtl/pipelined_main_decoder.sv
// pipelined_main_decoder
// RV32I main decoder feeding a chain of STAGES control pipeline registers (E, M, W, ...).
// Each stage has its own stall and flush. A stall on any stage also holds every
// upstream stage. The count of accepted illegal instructions saturates at 255.
// Optional feature: define CTRL_M_EXT_EN to decode R-type funct7 = 0000001 (mul/div).
module pipelined_main_decoder #(
    parameter int unsigned IMM_SRC_WIDTH = 3,
    parameter int unsigned ALU_OP_WIDTH  = 3,
    parameter int unsigned OP_WIDTH      = 7,
    parameter int unsigned STAGES        = 3
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [31:0]                      Instr,
    input  logic                             InstrValid,
    input  logic [STAGES-1:0]                Stall,
    input  logic [STAGES-1:0]                Flush,
    output logic                             Ready,
    output logic                             RegWriteD,
    output logic                             ALUSrcD,
    output logic                             MemWriteD,
    output logic                             MemReadD,
    output logic                             BranchD,
    output logic                             JumpD,
    output logic [IMM_SRC_WIDTH-1:0]         ImmSrcD,
    output logic [1:0]                       ResultSrcD,
    output logic [ALU_OP_WIDTH-1:0]          ALUOpD,
    output logic                             IllegalD,
    output logic [STAGES-1:0]                ValidS,
    output logic [STAGES-1:0]                RegWriteS,
    output logic [STAGES-1:0]                ALUSrcS,
    output logic [STAGES-1:0]                MemWriteS,
    output logic [STAGES-1:0]                MemReadS,
    output logic [STAGES-1:0]                BranchS,
    output logic [STAGES-1:0]                JumpS,
    output logic [2*STAGES-1:0]              ResultSrcS,
    output logic [ALU_OP_WIDTH*STAGES-1:0]   ALUOpS,
    output logic [7:0]                       IllegalCount
);

    localparam logic [OP_WIDTH-1:0] OP_LOAD  = OP_WIDTH'(7'b0000011);
    localparam logic [OP_WIDTH-1:0] OP_STORE = OP_WIDTH'(7'b0100011);
    localparam logic [OP_WIDTH-1:0] OP_R     = OP_WIDTH'(7'b0110011);
    localparam logic [OP_WIDTH-1:0] OP_I     = OP_WIDTH'(7'b0010011);
    localparam logic [OP_WIDTH-1:0] OP_B     = OP_WIDTH'(7'b1100011);
    localparam logic [OP_WIDTH-1:0] OP_AUIPC = OP_WIDTH'(7'b0010111);
    localparam logic [OP_WIDTH-1:0] OP_LUI   = OP_WIDTH'(7'b0110111);
    localparam logic [OP_WIDTH-1:0] OP_JALR  = OP_WIDTH'(7'b1100111);
    localparam logic [OP_WIDTH-1:0] OP_JAL   = OP_WIDTH'(7'b1101111);

    // Stage word layout: [0] valid, [1] RegWrite, [2] ALUSrc, [3] MemWrite, [4] MemRead,
    // [5] Branch, [6] Jump, [8:7] ResultSrc, [9 +: ALU_OP_WIDTH] ALUOp.
    localparam int unsigned CW = 9 + ALU_OP_WIDTH;

    logic [OP_WIDTH-1:0]           op;
    logic [6:0]                    funct7;
    logic                          is_muldiv;
    logic                          r_legal;
    logic                          unused_instr_bits;
    logic [CW-1:0]                 src0;
    logic [STAGES-1:0]             eff;
    logic [STAGES-1:0][CW-1:0]     stage_d;
    logic [STAGES-1:0][CW-1:0]     stage_q;
    logic [7:0]                    illegal_count_d;
    logic [7:0]                    illegal_count_q;

    assign op                = Instr[OP_WIDTH-1:0];
    assign funct7            = Instr[31:25];
    assign unused_instr_bits = ^Instr[24:OP_WIDTH];

`ifdef CTRL_M_EXT_EN
    assign is_muldiv = (funct7 == 7'b0000001);
`else
    assign is_muldiv = 1'b0;
`endif

    assign r_legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000) || is_muldiv;

    // Combinational decode of the D-stage instruction into the control word.
    always_comb begin
        RegWriteD  = 1'b0;
        ALUSrcD    = 1'b0;
        MemWriteD  = 1'b0;
        MemReadD   = 1'b0;
        BranchD    = 1'b0;
        JumpD      = 1'b0;
        ImmSrcD    = '0;
        ResultSrcD = 2'b00;
        ALUOpD     = '0;
        IllegalD   = 1'b0;
        case (op)
            OP_LOAD: begin
                RegWriteD  = 1'b1;
                ALUSrcD    = 1'b1;
                MemReadD   = 1'b1;
                ResultSrcD = 2'b01;
            end
            OP_STORE: begin
                ImmSrcD   = IMM_SRC_WIDTH'(3'b001);
                ALUSrcD   = 1'b1;
                MemWriteD = 1'b1;
            end
            OP_R: begin
                if (r_legal) begin
                    RegWriteD = 1'b1;
                    ALUOpD    = is_muldiv ? ALU_OP_WIDTH'(3'b101) : ALU_OP_WIDTH'(3'b010);
                end else begin
                    IllegalD = 1'b1;
                end
            end
            OP_I: begin
                RegWriteD = 1'b1;
                ALUSrcD   = 1'b1;
                ALUOpD    = ALU_OP_WIDTH'(3'b010);
            end
            OP_B: begin
                ImmSrcD = IMM_SRC_WIDTH'(3'b010);
                BranchD = 1'b1;
                ALUOpD  = ALU_OP_WIDTH'(3'b001);
            end
            OP_AUIPC: begin
                RegWriteD  = 1'b1;
                ImmSrcD    = IMM_SRC_WIDTH'(3'b011);
                ALUSrcD    = 1'b1;
                ResultSrcD = 2'b10;
                ALUOpD     = ALU_OP_WIDTH'(3'b100);
            end
            OP_LUI: begin
                RegWriteD = 1'b1;
                ImmSrcD   = IMM_SRC_WIDTH'(3'b011);
                ALUSrcD   = 1'b1;
                ALUOpD    = ALU_OP_WIDTH'(3'b100);
            end
            OP_JALR: begin
                RegWriteD  = 1'b1;
                ALUSrcD    = 1'b1;
                ResultSrcD = 2'b10;
                ALUOpD     = ALU_OP_WIDTH'(3'b011);
                JumpD      = 1'b1;
            end
            OP_JAL: begin
                RegWriteD  = 1'b1;
                ImmSrcD    = IMM_SRC_WIDTH'(3'b100);
                ResultSrcD = 2'b11;
                ALUOpD     = ALU_OP_WIDTH'(3'b100);
                JumpD      = 1'b1;
            end
            default: IllegalD = 1'b1;
        endcase
    end

    // Stage 0 source: decoded word, or a bubble when D holds no real instruction.
    assign src0  = InstrValid ? {ALUOpD, ResultSrcD, JumpD, BranchD, MemReadD, MemWriteD,
                                 ALUSrcD, RegWriteD, 1'b1}
                              : '0;
    assign Ready = ~eff[0];

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        logic          upstream_hold;
        logic [CW-1:0] src;
        logic [CW-1:0] nxt;

        if (g == 0) begin : g_head
            assign upstream_hold = 1'b0;
            assign src           = src0;
        end else begin : g_tail
            assign upstream_hold = eff[g-1];
            assign src           = stage_q[g-1];
        end

        // A stall anywhere downstream holds this stage too.
        assign eff[g] = |Stall[STAGES-1:g];

        // Next stage word: flush beats hold; if only upstream holds, insert a bubble.
        always_comb begin
            nxt = src;
            if (Flush[g]) begin
                nxt = '0;
            end else if (eff[g]) begin
                nxt = stage_q[g];
            end else if (upstream_hold) begin
                nxt = '0;
            end
        end

        assign stage_d[g] = nxt;

        assign ValidS[g]                                  = stage_q[g][0];
        assign RegWriteS[g]                               = stage_q[g][1];
        assign ALUSrcS[g]                                 = stage_q[g][2];
        assign MemWriteS[g]                               = stage_q[g][3];
        assign MemReadS[g]                                = stage_q[g][4];
        assign BranchS[g]                                 = stage_q[g][5];
        assign JumpS[g]                                   = stage_q[g][6];
        assign ResultSrcS[2*g +: 2]                       = stage_q[g][8:7];
        assign ALUOpS[ALU_OP_WIDTH*g +: ALU_OP_WIDTH]     = stage_q[g][9 +: ALU_OP_WIDTH];
    end

    // Count illegal instructions that actually enter stage 0, saturating at 255.
    always_comb begin
        illegal_count_d = illegal_count_q;
        if (InstrValid && IllegalD && Ready && !Flush[0] && (illegal_count_q != 8'hFF)) begin
            illegal_count_d = illegal_count_q + 8'd1;
        end
    end

    assign IllegalCount = illegal_count_q;

    // Pipeline and counter state; reset clears every stage regardless of stall/flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q         <= '0;
            illegal_count_q <= 8'd0;
        end else begin
            stage_q         <= stage_d;
            illegal_count_q <= illegal_count_d;
        end
    end

endmodule

// File: tb/tb_pipelined_main_decoder.sv
// Self-checking bench for pipelined_main_decoder (STAGES = 3): decode table vectors,
// directed multi-cycle sequences and randomized traffic against a behavioural model.
module tb_pipelined_main_decoder;

    localparam int STAGES = 3;
`ifdef CTRL_M_EXT_EN
    localparam bit MEn = 1'b1;
`else
    localparam bit MEn = 1'b0;
`endif

    typedef struct packed {
        logic       rw;
        logic [2:0] imm;
        logic       alusrc;
        logic       mw;
        logic       mr;
        logic [1:0] rs;
        logic       br;
        logic [2:0] aluop;
        logic       j;
        logic       ill;
    } ctrl_t;

    typedef struct packed {
        logic  v;
        ctrl_t c;
    } slot_t;

    typedef struct {
        string       name;
        logic [31:0] instr;
        ctrl_t       exp;
    } vec_t;

    typedef struct {
        logic [6:0] op;
        ctrl_t      c;
    } rule_t;

    localparam ctrl_t ILL = 15'b0_000_0_0_0_00_0_000_0_1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   rst;
    logic [31:0]            Instr;
    logic                   InstrValid;
    logic [STAGES-1:0]      Stall;
    logic [STAGES-1:0]      Flush;
    logic                   Ready;
    logic                   RegWriteD, ALUSrcD, MemWriteD, MemReadD, BranchD, JumpD;
    logic [2:0]             ImmSrcD;
    logic [1:0]             ResultSrcD;
    logic [2:0]             ALUOpD;
    logic                   IllegalD;
    logic [STAGES-1:0]      ValidS, RegWriteS, ALUSrcS, MemWriteS, MemReadS, BranchS, JumpS;
    logic [2*STAGES-1:0]    ResultSrcS;
    logic [3*STAGES-1:0]    ALUOpS;
    logic [7:0]             IllegalCount;

    pipelined_main_decoder #(
        .IMM_SRC_WIDTH(3),
        .ALU_OP_WIDTH (3),
        .OP_WIDTH     (7),
        .STAGES       (STAGES)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .Instr       (Instr),
        .InstrValid  (InstrValid),
        .Stall       (Stall),
        .Flush       (Flush),
        .Ready       (Ready),
        .RegWriteD   (RegWriteD),
        .ALUSrcD     (ALUSrcD),
        .MemWriteD   (MemWriteD),
        .MemReadD    (MemReadD),
        .BranchD     (BranchD),
        .JumpD       (JumpD),
        .ImmSrcD     (ImmSrcD),
        .ResultSrcD  (ResultSrcD),
        .ALUOpD      (ALUOpD),
        .IllegalD    (IllegalD),
        .ValidS      (ValidS),
        .RegWriteS   (RegWriteS),
        .ALUSrcS     (ALUSrcS),
        .MemWriteS   (MemWriteS),
        .MemReadS    (MemReadS),
        .BranchS     (BranchS),
        .JumpS       (JumpS),
        .ResultSrcS  (ResultSrcS),
        .ALUOpS      (ALUOpS),
        .IllegalCount(IllegalCount)
    );

    ctrl_t d_got;
    assign d_got = {RegWriteD, ImmSrcD, ALUSrcD, MemWriteD, MemReadD, ResultSrcD, BranchD,
                    ALUOpD, JumpD, IllegalD};

    int    checks   = 0;
    int    failures = 0;
    slot_t m_st[STAGES];
    int    m_cnt;
    rule_t rules[9];
    vec_t  tbl[15];
    logic  ready_seen;
    int    w_seen;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk(input logic [6:0] f7, input logic [6:0] op);
        return {f7, 18'h2A5A5, op};
    endfunction

    // Reference decode: look the opcode up in the rule table, then apply R-type funct7 rules.
    function automatic ctrl_t ref_decode(input logic [31:0] ins);
        ctrl_t r;
        r = ILL;
        for (int i = 0; i < 9; i++) begin
            if (rules[i].op == ins[6:0]) r = rules[i].c;
        end
        if (ins[6:0] == 7'b0110011) begin
            if (ins[31:25] == 7'h01 && MEn) r.aluop = 3'b101;
            else if (ins[31:25] != 7'h00 && ins[31:25] != 7'h20) r = ILL;
        end
        return r;
    endfunction

    function automatic logic bitk(input logic [STAGES-1:0] v, input int k);
        logic [STAGES-1:0] t;
        t = v >> k;
        return t[0];
    endfunction

    function automatic logic [11:0] got_stage(input int k);
        logic [2*STAGES-1:0] rs;
        logic [3*STAGES-1:0] al;
        rs = ResultSrcS >> (2 * k);
        al = ALUOpS >> (3 * k);
        return {bitk(ValidS, k), bitk(RegWriteS, k), bitk(ALUSrcS, k), bitk(MemWriteS, k),
                bitk(MemReadS, k), rs[1:0], bitk(BranchS, k), al[2:0], bitk(JumpS, k)};
    endfunction

    function automatic logic [11:0] exp_stage(input slot_t s);
        return {s.v, s.c.rw, s.c.alusrc, s.c.mw, s.c.mr, s.c.rs, s.c.br, s.c.aluop, s.c.j};
    endfunction

    // One clock: drive inputs, check D outputs, advance the model, check stages after the edge.
    task automatic cycle(input logic [31:0] ins, input logic iv, input logic [2:0] st,
                         input logic [2:0] fl, input logic r);
        ctrl_t dec;
        slot_t nxt[STAGES];
        slot_t src;
        logic  held;
        logic  up_held;
        Instr = ins; InstrValid = iv; Stall = st; Flush = fl; rst = r;
        #1;
        dec = ref_decode(ins);
        check("decode_d", 32'(d_got), 32'(dec));
        ready_seen = Ready;
        check("ready", 32'(Ready), 32'(st == 3'b000));
        for (int k = 0; k < STAGES; k++) begin
            held    = |(st >> k);
            up_held = (k > 0) && (|(st >> (k - 1)));
            if (k == 0) begin
                src.v = iv;
                src.c = iv ? dec : '0;
            end else begin
                src = m_st[k-1];
            end
            if (r || fl[k])   nxt[k] = '0;
            else if (held)    nxt[k] = m_st[k];
            else if (up_held) nxt[k] = '0;
            else              nxt[k] = src;
        end
        if (r) m_cnt = 0;
        else if (iv && dec.ill && st == 3'b000 && !fl[0] && m_cnt < 255) m_cnt++;
        @(posedge clk);
        #1;
        m_st = nxt;
        for (int k = 0; k < STAGES; k++) begin
            check($sformatf("stage%0d", k), 32'(got_stage(k)), 32'(exp_stage(m_st[k])));
        end
        check("illegal_count", 32'(IllegalCount), 32'(m_cnt));
        if (bitk(ValidS, 2)) w_seen++;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0] op;
        logic [6:0] f7;
        int unsigned s;
        s  = $urandom_range(0, 10);
        op = (s < 9) ? rules[s].op : 7'($urandom);
        case ($urandom_range(0, 3))
            0:       f7 = 7'h00;
            1:       f7 = 7'h20;
            2:       f7 = 7'h01;
            default: f7 = 7'($urandom);
        endcase
        return {f7, 18'($urandom), op};
    endfunction

    logic [31:0] prog[5];
    int          pi;

    initial begin
        rst = 1'b1; Instr = '0; InstrValid = 1'b0; Stall = '0; Flush = '0;
        m_cnt = 0; w_seen = 0; ready_seen = 1'b0;
        for (int k = 0; k < STAGES; k++) m_st[k] = '0;

        rules[0] = '{7'b0000011, 15'b1_000_1_0_1_01_0_000_0_0};
        rules[1] = '{7'b0100011, 15'b0_001_1_1_0_00_0_000_0_0};
        rules[2] = '{7'b0110011, 15'b1_000_0_0_0_00_0_010_0_0};
        rules[3] = '{7'b0010011, 15'b1_000_1_0_0_00_0_010_0_0};
        rules[4] = '{7'b1100011, 15'b0_010_0_0_0_00_1_001_0_0};
        rules[5] = '{7'b0010111, 15'b1_011_1_0_0_10_0_100_0_0};
        rules[6] = '{7'b0110111, 15'b1_011_1_0_0_00_0_100_0_0};
        rules[7] = '{7'b1100111, 15'b1_000_1_0_0_10_0_011_1_0};
        rules[8] = '{7'b1101111, 15'b1_100_0_0_0_11_0_100_1_0};

        tbl[0]  = '{"lw",     mk(7'h00, 7'b0000011), 15'b1_000_1_0_1_01_0_000_0_0};
        tbl[1]  = '{"sw",     mk(7'h00, 7'b0100011), 15'b0_001_1_1_0_00_0_000_0_0};
        tbl[2]  = '{"add",    mk(7'h00, 7'b0110011), 15'b1_000_0_0_0_00_0_010_0_0};
        tbl[3]  = '{"sub",    mk(7'h20, 7'b0110011), 15'b1_000_0_0_0_00_0_010_0_0};
        tbl[4]  = '{"addi",   mk(7'h7F, 7'b0010011), 15'b1_000_1_0_0_00_0_010_0_0};
        tbl[5]  = '{"beq",    mk(7'h00, 7'b1100011), 15'b0_010_0_0_0_00_1_001_0_0};
        tbl[6]  = '{"auipc",  mk(7'h00, 7'b0010111), 15'b1_011_1_0_0_10_0_100_0_0};
        tbl[7]  = '{"lui",    mk(7'h00, 7'b0110111), 15'b1_011_1_0_0_00_0_100_0_0};
        tbl[8]  = '{"jalr",   mk(7'h00, 7'b1100111), 15'b1_000_1_0_0_10_0_011_1_0};
        tbl[9]  = '{"jal",    mk(7'h00, 7'b1101111), 15'b1_100_0_0_0_11_0_100_1_0};
        tbl[10] = '{"op0",    mk(7'h00, 7'b0000000), ILL};
        tbl[11] = '{"op7f",   mk(7'h00, 7'b1111111), ILL};
        tbl[12] = '{"r_f7_2", mk(7'h02, 7'b0110011), ILL};
        tbl[13] = '{"r_f7_40",mk(7'h40, 7'b0110011), ILL};
        tbl[14] = '{"mul",    mk(7'h01, 7'b0110011),
                    MEn ? 15'b1_000_0_0_0_00_0_101_0_0 : ILL};

        // Reset
        cycle(32'h0, 1'b0, 3'b000, 3'b000, 1'b1);
        cycle(32'h0, 1'b0, 3'b000, 3'b000, 1'b1);
        check("reset_valid", 32'(ValidS), 32'h0);
        check("reset_regwrite", 32'(RegWriteS), 32'h0);
        check("reset_count", 32'(IllegalCount), 32'h0);

        // Decode table (held in reset so the pipeline stays empty)
        for (int i = 0; i < 15; i++) begin
            Instr = tbl[i].instr;
            #1;
            check({"dec_", tbl[i].name}, 32'(d_got), 32'(tbl[i].exp));
        end
        @(posedge clk);
        #1;

        // lw, sw, add, beq, jal back to back
        prog[0] = tbl[0].instr; prog[1] = tbl[1].instr; prog[2] = tbl[2].instr;
        prog[3] = tbl[5].instr; prog[4] = tbl[9].instr;
        cycle(prog[0], 1'b1, 3'b000, 3'b000, 1'b0);
        cycle(prog[1], 1'b1, 3'b000, 3'b000, 1'b0);
        cycle(prog[2], 1'b1, 3'b000, 3'b000, 1'b0);
        check("lw_w_valid", 32'(bitk(ValidS, 2)), 32'h1);
        check("lw_w_regwrite", 32'(bitk(RegWriteS, 2)), 32'h1);
        check("lw_w_memread", 32'(bitk(MemReadS, 2)), 32'h1);
        check("lw_w_resultsrc", 32'(ResultSrcS[5:4]), 32'h1);
        cycle(prog[3], 1'b1, 3'b000, 3'b000, 1'b0);
        check("sw_w_memwrite", 32'(bitk(MemWriteS, 2)), 32'h1);
        check("sw_w_memread", 32'(bitk(MemReadS, 2)), 32'h0);
        cycle(prog[4], 1'b1, 3'b000, 3'b000, 1'b0);
        check("add_w_aluop", 32'(ALUOpS[8:6]), 32'h2);
        for (int i = 0; i < 3; i++) cycle(32'h0, 1'b0, 3'b000, 3'b000, 1'b0);
        check("jal_drained", 32'(ValidS), 32'h0);

        // Stall on stage 1 for two cycles mid-stream; D re-presents until accepted
        w_seen = 0;
        pi = 0;
        for (int c = 0; c < 12; c++) begin
            logic [2:0] st;
            st = (c == 2 || c == 3) ? 3'b010 : 3'b000;
            if (pi < 5) cycle(prog[pi], 1'b1, st, 3'b000, 1'b0);
            else        cycle(32'h0, 1'b0, st, 3'b000, 1'b0);
            if (st != 3'b000) begin
                check("stall_ready", 32'(ready_seen), 32'h0);
                check("stall_w_bubble", 32'(bitk(ValidS, 2)), 32'h0);
            end
            if (ready_seen && pi < 5) pi++;
        end
        check("stall_no_loss", 32'(w_seen), 32'd5);

        // Stall and flush together on stage 0 with add in D
        cycle(tbl[2].instr, 1'b1, 3'b001, 3'b001, 1'b0);
        check("sf_ready", 32'(ready_seen), 32'h0);
        check("sf_e_bubble", 32'(bitk(ValidS, 0)), 32'h0);
        cycle(tbl[2].instr, 1'b1, 3'b000, 3'b000, 1'b0);
        check("sf_e_valid", 32'(bitk(ValidS, 0)), 32'h1);
        check("sf_e_aluop", 32'(ALUOpS[2:0]), 32'h2);

        // Illegal counter saturation
        cycle(32'h0, 1'b0, 3'b000, 3'b000, 1'b1);
        for (int i = 0; i < 300; i++) cycle(32'h0, 1'b1, 3'b000, 3'b000, 1'b0);
        check("ill_d", 32'(IllegalD), 32'h1);
        check("ill_sat", 32'(IllegalCount), 32'd255);
        for (int i = 0; i < 4; i++) cycle(32'h0, 1'b0, 3'b000, 3'b000, 1'b0);
        check("ill_hold", 32'(IllegalCount), 32'd255);

        // Reset mid-stream with all stages valid, stall and flush asserted
        cycle(tbl[2].instr, 1'b1, 3'b000, 3'b000, 1'b0);
        cycle(tbl[0].instr, 1'b1, 3'b000, 3'b000, 1'b0);
        cycle(tbl[1].instr, 1'b1, 3'b000, 3'b000, 1'b0);
        check("pre_rst_full", 32'(ValidS), 32'h7);
        cycle(tbl[9].instr, 1'b1, 3'b111, 3'b101, 1'b1);
        check("rst_valid", 32'(ValidS), 32'h0);
        check("rst_regwrite", 32'(RegWriteS), 32'h0);
        check("rst_memread", 32'(MemReadS), 32'h0);
        check("rst_aluop", 32'(ALUOpS), 32'h0);
        check("rst_count", 32'(IllegalCount), 32'h0);

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            logic [2:0] st;
            logic [2:0] fl;
            st[0] = ($urandom_range(0, 5) == 0); st[1] = ($urandom_range(0, 7) == 0);
            st[2] = ($urandom_range(0, 9) == 0);
            fl[0] = ($urandom_range(0, 7) == 0); fl[1] = ($urandom_range(0, 9) == 0);
            fl[2] = ($urandom_range(0, 11) == 0);
            cycle(rand_instr(), 1'($urandom_range(0, 3) != 0), st, fl,
                  1'($urandom_range(0, 99) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
